// File: rtl/nios_ii_system_led_pkg.sv
// rtl/nios_ii_system_led_pkg.sv - shared widths and types for the LED dimmer
//
// Purpose: LED word width, PWM counter width, full-brightness code and
// stretch counter width, plus the vector typedefs used by the dimmer files.
// Ports: none (package).

package nios_ii_system_led_pkg;

  localparam int LED_W = 8;
  localparam int PWM_W = 4;
  localparam int SC_W  = 4;

  localparam logic [PWM_W-1:0] PWM_FULL = 4'hF;

  typedef logic [LED_W-1:0] led_vec_t;
  typedef logic [PWM_W-1:0] pwm_t;

endpackage

// File: rtl/nios_ii_system_led_stretch.sv
// rtl/nios_ii_system_led_stretch.sv - per-LED rising-edge pulse stretcher
//
// Purpose: detects a rising edge on one registered LED bit and keeps the bit
// lit for STRETCH_PERIODS PWM periods afterwards, so short software writes
// remain visible.
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   in_bit     in   registered LED bit (already synchronous to clk)
//   period_end in   one-cycle strobe at the last clock of each PWM period
//   out_bit    out  in_bit OR'ed with "stretch still running"

module nios_ii_system_led_stretch
  import nios_ii_system_led_pkg::*;
#(
  parameter int STRETCH_PERIODS = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_bit,
  input  logic period_end,
  output logic out_bit
);

  localparam logic [SC_W-1:0] SC_LOAD = SC_W'(STRETCH_PERIODS);

  logic            in_d;
  logic [SC_W-1:0] sc;
  logic            rise;

  assign rise = in_bit & ~in_d;

  // A rise coinciding with period_end reloads the full count; the reload is
  // checked first so the same-cycle decrement is discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_d <= 1'b0;
      sc   <= '0;
    end else begin
      in_d <= in_bit;
      if (rise) begin
        sc <= SC_LOAD;
      end else if (period_end && (sc != '0)) begin
        sc <= sc - 1'b1;
      end
    end
  end

  assign out_bit = in_bit | (sc != '0);

endmodule

// File: rtl/nios_ii_system_led_dimmer.sv
// rtl/nios_ii_system_led_dimmer.sv - global PWM dimmer and pulse stretcher for the red-LED PIO
//
// Purpose: sits between the PIO out_port and the LED pins. Applies a 16-level
// brightness (sampled only at period boundaries so the duty never glitches)
// and, when NIOS_II_SYSTEM_LED_DIMMER_STRETCH_EN is defined, stretches short
// ON pulses to a minimum number of PWM periods. Without the macro the input
// pattern passes straight through the duty gate.
// Ports:
//   clk         in   system clock (same as the PIO)
//   reset_n     in   asynchronous active-low reset
//   led_in      in   LED pattern from the PIO out_port
//   brightness  in   duty code, 0 = off, 15 = fully on
//   led_out     out  registered LED pin drive
//   period_tick out  one-cycle pulse, one clock after each PWM period end

module nios_ii_system_led_dimmer
  import nios_ii_system_led_pkg::*;
#(
  parameter int PRESCALE        = 64
`ifdef NIOS_II_SYSTEM_LED_DIMMER_STRETCH_EN
  ,
  parameter int STRETCH_PERIODS = 8
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [LED_W-1:0] led_in,
  input  logic [PWM_W-1:0] brightness,
  output logic [LED_W-1:0] led_out,
  output logic             period_tick
);

  localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0] pre_cnt;
  pwm_t             pwm_cnt;
  pwm_t             bright_q;
  led_vec_t         led_q;
  led_vec_t         eff;
  logic             step;
  logic             period_end;
  logic             on;

  assign step       = (pre_cnt == PRE_LAST);
  assign period_end = step && (pwm_cnt == PWM_FULL);

  // Code 15 must be a true 100% duty, which pwm_cnt < 15 alone cannot give.
  assign on = (bright_q == PWM_FULL) ? 1'b1 : (pwm_cnt < bright_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      bright_q    <= PWM_FULL;
      led_q       <= '0;
      period_tick <= 1'b0;
      led_out     <= '0;
    end else begin
      pre_cnt <= step ? '0 : pre_cnt + 1'b1;
      if (step) begin
        pwm_cnt <= pwm_cnt + 1'b1;
      end
      if (period_end) begin
        bright_q <= brightness;
      end
      led_q       <= led_in;
      period_tick <= period_end;
      led_out     <= eff & {LED_W{on}};
    end
  end

`ifdef NIOS_II_SYSTEM_LED_DIMMER_STRETCH_EN
  for (genvar i = 0; i < LED_W; i++) begin : g_stretch
    nios_ii_system_led_stretch #(
      .STRETCH_PERIODS(STRETCH_PERIODS)
    ) u_stretch (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_bit     (led_q[i]),
      .period_end (period_end),
      .out_bit    (eff[i])
    );
  end
`else
  assign eff = led_q;
`endif

endmodule

// File: doc/nios_ii_system_led_dimmer.md
Name: nios_ii_system_led_dimmer

Overview:
- Downstream consumer of the 8-bit red-LED PIO output word; sits between the PIO's out_port and the board LED pins.
- Applies a global 16-level PWM brightness to the LED pattern.
- Stretches short ON pulses so brief software writes stay visible.
- Single clock domain, same clock as the PIO; no bus interface.

Parameters:
- PRESCALE, 64, clocks per PWM step (>=2); PWM period = 16*PRESCALE clocks.
- STRETCH_PERIODS, 8, minimum PWM periods an LED stays lit after a rising edge (1..15).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- led_in  input  8  LED pattern from the PIO out_port
- brightness  input  4  global duty code: 0=off, 15=fully on
- led_out  output  8  registered LED pin drive
- period_tick  output  1  one-cycle pulse at each PWM period end

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: led_out=0; period_tick=0; pre_cnt=0; pwm_cnt=0; bright_q=15; led_q=0; led_q_d=0; all stretch counters=0.
- Reset mid-operation clears everything immediately (asynchronous). Counting restarts from 0 on the first clock after deassertion.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1, then wraps to 0.
  - step=1 in the cycle where pre_cnt==PRESCALE-1.
- PWM counter:
  - 4-bit pwm_cnt increments on step and wraps 15->0.
  - period_end = step && pwm_cnt==15.
  - period_tick is a registered copy of period_end, so it lags by 1 clock.
- Brightness sampling:
  - bright_q loads brightness only on period_end; it never changes mid-period (glitch-free).
  - A brightness change takes effect from the next period start.
- Duty:
  - on = 1 if bright_q==15.
  - Otherwise on = (pwm_cnt < bright_q).
  - bright_q=0 gives always off; code k (1..14) gives k/16 duty; 15 gives 100%.
- Input path:
  - led_q <= led_in every clock.
  - led_q_d <= led_q every clock.
  - rise[i] = led_q[i] & ~led_q_d[i].
- Stretch, per bit, 4-bit counter sc[i]:
  - On rise[i], load STRETCH_PERIODS.
  - Else, on period_end with sc[i]!=0, decrement by 1.
  - rise and period_end in the same cycle: the load wins.
  - Counter saturates at 0; it never wraps.
- Effective pattern: eff[i] = led_q[i] | (sc[i]!=0).
- Output: led_out <= eff & {8{on}}. The brightness gating also applies to stretched bits.
- Latency:
  - led_in rise to led_out rise: 2 clocks at bright_q=15.
  - led_in fall to led_out fall: 2 clocks if no stretch is active.
  - An isolated 1-clock input pulse lights the LED for between STRETCH_PERIODS-1 and STRETCH_PERIODS periods, plus partial-period slack.
- led_in held high: sc stays loaded only at the edge, then counts down. The LED stays on via led_q.

Optional Feature:
- Macro: NIOS_II_SYSTEM_LED_DIMMER_STRETCH_EN
- Defined: stretch counters present as described.
- Undefined: no stretch logic; eff = led_q. A 1-clock input pulse produces at most a 1-clock output pulse, gated by duty.
- All other behaviour is identical in both builds.

Decomposition:
- Package nios_ii_system_led_pkg:
  - LED_W=8, PWM_W=4, PWM_FULL=4'hF, SC_W=4.
  - Typedef led_vec_t [LED_W-1:0].
  - Typedef pwm_t [PWM_W-1:0].
- Sub-module nios_ii_system_led_stretch:
  - One bit's edge detect plus counter.
  - Ports: clk, reset_n, in_bit, period_end, out_bit.
  - Instantiated LED_W times under the macro.

Test Plan (PRESCALE=2, STRETCH_PERIODS=3; period=32 clocks):
- Reset, then led_in=8'hFF, brightness=15 -> led_out=8'hFF exactly 2 clocks later; stays 8'hFF continuously; period_tick every 32 clocks.
- led_in=8'h0F, brightness=4 after one period_end -> in each period led_out=8'h0F for 8 clocks (pwm_cnt 0..3), 8'h00 for 24.
- brightness changed 4->10 mid-period -> current period keeps 8-clock high; next period 20-clock high; no glitch.
- brightness=0 with led_in=8'hFF -> led_out=0 for every clock after the next period_end; brightness=15 restores 8'hFF next period.
- STRETCH_EN, brightness=15, led_in bit0 pulsed 1 clock -> led_out[0] high until the third subsequent period_end, then low. Repeat with the pulse coincident with period_end -> counter loads 3, not 2.
- Assert reset_n low mid-period with led_out=8'hAA -> led_out=0 and period_tick=0 asynchronously; after release, bright_q=15 and first period_tick 32 clocks later.
